// File: rtl/acc_frame_ctrl.sv
// acc_frame_ctrl
//   Folds a stream of unsigned IN_W-bit terms into an ACC_W-bit running sum
//   (modulo 2^ACC_W) and emits one result per frame over a valid/ready
//   handshake. A frame closes on in_last or once it holds N_MAX terms.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   clear      synchronous abort of the current frame; any held result is dropped
//   in_valid   input term valid
//   in_ready   block can accept a term (low only while a result is held)
//   in_data    unsigned input term, zero-extended to ACC_W
//   in_last    term closes its frame
//   out_valid  frame result valid
//   out_ready  consumer accepts the result
//   out_data   frame sum modulo 2^ACC_W
//   out_count  number of terms in the frame
//   out_ovf    a carry out of bit ACC_W-1 occurred during the frame
module acc_frame_ctrl #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 20,
  parameter int N_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  localparam logic [7:0] NMAX8 = 8'(N_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_count;
  logic               r_ovf;

  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic [7:0]         r_out_count;
  logic               r_out_ovf;

  logic [ACC_W-1:0]   w_acc_nxt;
  logic [7:0]         w_cnt_nxt;
  logic               w_ovf_nxt;
  logic               w_close;
  logic               w_release;

  logic               w_in_ready;
  logic               w_accept;
  logic [ACC_W-1:0]   w_term_ext;
  logic [ACC_W:0]     w_sum;
  logic [7:0]         w_cnt_inc;

  assign w_in_ready = (r_state != S_HOLD);
  // clear drops a presented term even though in_ready may read 1
  assign w_accept   = in_valid && w_in_ready && !clear;
  assign w_term_ext = ACC_W'(in_data);
  // Top bit of the widened sum is the carry out of the accumulator
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_term_ext};
  assign w_cnt_inc  = r_count + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_count;
    w_ovf_nxt   = r_ovf;
    w_close     = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt = w_term_ext;
          w_cnt_nxt = 8'd1;
          w_ovf_nxt = 1'b0;
          if (in_last || (NMAX8 == 8'd1)) begin
            w_state_nxt = S_HOLD;
            w_close     = 1'b1;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = w_sum[ACC_W-1:0];
          w_ovf_nxt = r_ovf | w_sum[ACC_W];
          w_cnt_nxt = w_cnt_inc;
          if (in_last || (w_cnt_inc == NMAX8)) begin
            w_state_nxt = S_HOLD;
            w_close     = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_release   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear) begin
      // Result registers keep their last value; only the valid is dropped
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_close) begin
        // Result is captured from the post-update values on the closing edge
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
        r_out_ovf   <= w_ovf_nxt;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_acc_frame_ctrl.sv
// Bench for acc_frame_ctrl: two instances (N_MAX=16 and N_MAX=32) share one
// input stream and out_ready; each is tracked by a frame-level model that
// keeps the true integer sum and term count of the open frame.
module tb_acc_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [19:0] a_out_data;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [19:0] b_out_data;
  logic [7:0]  b_out_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acc_frame_ctrl #(.IN_W(16), .ACC_W(20), .N_MAX(16)) u_dut16 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  acc_frame_ctrl #(.IN_W(16), .ACC_W(20), .N_MAX(32)) u_dut32 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: true sum of the open frame, its size, and the held result
  int unsigned m_sum [2];
  int unsigned m_cnt [2];
  bit          m_hold[2];
  logic [19:0] m_od  [2];
  logic [7:0]  m_oc  [2];
  logic        m_oo  [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
      m_od[k] = '0; m_oc[k] = '0; m_oo[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int unsigned nmax;
      nmax = (k == 0) ? 16 : 32;
      if (rst) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
        m_od[k] = '0; m_oc[k] = '0; m_oo[k] = 1'b0;
      end else if (clear) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
      end else if (m_hold[k]) begin
        if (out_ready) m_hold[k] = 0;
      end else if (in_valid) begin
        m_sum[k] += in_data;
        m_cnt[k] += 1;
        if (in_last || m_cnt[k] == nmax) begin
          m_hold[k] = 1;
          m_od[k]   = 20'(m_sum[k] % 32'h0010_0000);
          m_oc[k]   = 8'(m_cnt[k]);
          m_oo[k]   = (m_sum[k] >= 32'h0010_0000);
          m_sum[k]  = 0;
          m_cnt[k]  = 0;
        end
      end
    end
    #1;
    chk("dut16 {rdy,vld,ovf,cnt,data}",
        {33'b0, a_in_ready, a_out_valid, a_out_ovf, a_out_count, a_out_data},
        {33'b0, !m_hold[0], m_hold[0], m_oo[0], m_oc[0], m_od[0]});
    chk("dut32 {rdy,vld,ovf,cnt,data}",
        {33'b0, b_in_ready, b_out_valid, b_out_ovf, b_out_count, b_out_data},
        {33'b0, !m_hold[1], m_hold[1], m_oo[1], m_oc[1], m_od[1]});
  end

  // Drive one cycle of inputs at negedge, return just after the sampling edge
  task automatic cyc(input logic v, input logic [15:0] d, input logic l,
                     input logic r, input logic c);
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r; clear = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset out_valid", a_out_valid, 0);
    chk("reset out_data", a_out_data, 0);
    chk("reset in_ready", a_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Single term with in_last
    cyc(1, 16'h1234, 1, 0, 0);
    chk("single out_valid", a_out_valid, 1);
    chk("single out_data", a_out_data, 20'h01234);
    chk("single out_count", a_out_count, 1);
    chk("single out_ovf", a_out_ovf, 0);
    cyc(0, 0, 0, 1, 0);
    chk("single release", a_out_valid, 0);

    // Four 0xFFFF, last on the 4th, out_ready held high
    for (int i = 0; i < 4; i++) cyc(1, 16'hFFFF, (i == 3), 1, 0);
    chk("four out_data", a_out_data, 20'h3FFFC);
    chk("four out_count", a_out_count, 4);
    chk("four out_ovf", a_out_ovf, 0);
    chk("four bubble in_ready", a_in_ready, 0);
    cyc(0, 0, 0, 1, 0);
    chk("four in_ready back", a_in_ready, 1);

    // 0xFFFF stream: dut16 closes at 16, dut32 closes on in_last at 17
    for (int i = 0; i < 16; i++) cyc(1, 16'hFFFF, 0, 1, 0);
    chk("nmax16 out_data", a_out_data, 20'hFFFF0);
    chk("nmax16 out_count", a_out_count, 16);
    chk("nmax16 out_ovf", a_out_ovf, 0);
    chk("nmax16 in_ready", a_in_ready, 0);
    cyc(1, 16'hFFFF, 1, 1, 0);
    chk("dut32 17 out_data", b_out_data, 20'h0FFEF);
    chk("dut32 17 out_count", b_out_count, 17);
    chk("dut32 17 out_ovf", b_out_ovf, 1);
    chk("nmax16 17th held off", a_out_valid, 0);
    cyc(1, 16'hFFFF, 1, 1, 0);
    chk("nmax16 17th new frame", a_out_data, 20'h0FFFF);
    chk("nmax16 17th count", a_out_count, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 16'h0001, 1, 1, 0);
    chk("dut32 ovf cleared", b_out_ovf, 0);
    cyc(0, 0, 0, 1, 0);

    // Backpressure
    cyc(1, 16'h0010, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h0007, 1, 0, 0);
      chk("bp out_data stable", a_out_data, 20'h00010);
      chk("bp in_ready low", a_in_ready, 0);
    end
    cyc(1, 16'h0007, 1, 1, 0);
    chk("bp released", a_out_valid, 0);
    cyc(1, 16'h0007, 1, 0, 0);
    chk("bp pending accepted", a_out_data, 20'h00007);
    cyc(0, 0, 0, 1, 0);

    // Abort after three terms, then a one-term frame
    for (int i = 0; i < 3; i++) cyc(1, 16'h0010, 0, 1, 0);
    cyc(1, 16'h0100, 0, 1, 1);
    chk("clear out_valid", a_out_valid, 0);
    chk("clear in_ready", a_in_ready, 1);
    cyc(1, 16'h0005, 1, 0, 0);
    chk("after clear out_data", a_out_data, 20'h00005);
    chk("after clear out_count", a_out_count, 1);

    // Reset while holding
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(posedge clk);
    #2;
    chk("rst hold out_valid", a_out_valid, 0);
    chk("rst hold outputs", {a_out_data, a_out_count, a_out_ovf}, 0);
    @(negedge clk);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      in_last   = ($urandom_range(0, 19) < 3);
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 99) < 2);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    in_valid = 0; clear = 0; rst = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
